// File: rtl/data_mem_unit.sv
// data_mem_unit: byte-addressable data memory for the memory stage of the single-cycle datapath.
// After reset a clear sequencer zeroes the whole array, one word per cycle, and holds o_ready low
// until it is done. Loads are combinational; stores commit on the rising clock edge.
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        synchronous, active-high reset
//   i_mem_read     load request this cycle
//   i_mem_write    store request this cycle
//   i_size         access size: 00 byte, 01 halfword, 10 word, 11 reserved
//   i_unsigned     loads only: 1 zero-extends, 0 sign-extends
//   i_addr         byte address (upper bits ignored, addresses alias modulo 4*DEPTH)
//   i_wd           store data, right-aligned
//   o_rd           load data, combinational
//   o_ready        high once the array has been cleared
//   o_fault        combinational: current request is misaligned or uses the reserved size
//   o_fault_sticky registered: a fault has occurred since reset
module data_mem_unit #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd,
  output logic        o_ready,
  output logic        o_fault,
  output logic        o_fault_sticky
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] CNT_LAST = '1;

  typedef enum logic {
    StClear,
    StReady
  } state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [DEPTH_LOG2-1:0] r_cnt;
  logic [DEPTH_LOG2-1:0] w_cnt_d;
  logic                  w_clr_we;
  logic                  r_fault_sticky;

  logic [31:0] r_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_word;
  logic                  w_ready;
  logic                  w_misalign;
  logic                  w_access_ok;
  logic                  w_user_we;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_rd;

  // Address bits above the array are deliberately ignored (aliasing).
  logic w_unused_addr;
  assign w_unused_addr = ^i_addr[31:DEPTH_LOG2+2];

  assign w_idx   = i_addr[DEPTH_LOG2+1:2];
  assign w_word  = r_mem[w_idx];
  assign w_ready = (r_state == StReady);

  // Clear sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StClear;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_clr_we  = 1'b0;
    unique case (r_state)
      StClear: begin
        w_clr_we = 1'b1;
        w_cnt_d  = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_d = StReady;
        end
      end
      StReady: begin
        w_state_d = StReady;
      end
      default: begin
        w_state_d = StClear;
      end
    endcase
  end

  always_comb begin
    case (i_size)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = i_addr[0];
      2'b10:   w_misalign = (i_addr[1:0] != 2'b00);
      default: w_misalign = 1'b1;
    endcase
  end

  assign o_fault     = w_ready & (i_mem_read | i_mem_write) & w_misalign;
  assign w_access_ok = w_ready & ~w_misalign;
  // A store coinciding with a reset edge is dropped; the array is about to be cleared anyway.
  assign w_user_we   = w_access_ok & i_mem_write & ~i_reset;

  // Replicate store data across lanes so only the byte enables depend on the address.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    case (i_size)
      2'b00: begin
        w_be    = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_wd[7:0]}};
      end
      2'b01: begin
        w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_wd[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wdata = i_wd;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
      end
    endcase
  end

  // Single write port shared by the clear sequencer and user stores.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_clr_we) begin
      r_mem[r_cnt] <= 32'h0;
    end else if (w_user_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    case (i_addr[1:0])
      2'b00:   w_byte = w_word[7:0];
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = i_addr[1] ? w_word[31:16] : w_word[15:0];
  end

  always_comb begin
    w_rd = 32'h0;
    if (w_access_ok && i_mem_read) begin
      case (i_size)
        2'b00:   w_rd = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        2'b01:   w_rd = {{16{~i_unsigned & w_half[15]}}, w_half};
        2'b10:   w_rd = w_word;
        default: w_rd = 32'h0;
      endcase
    end
  end

  assign o_rd    = w_rd;
  assign o_ready = w_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fault_sticky <= 1'b0;
    end else if (o_fault) begin
      r_fault_sticky <= 1'b1;
    end
  end

  assign o_fault_sticky = r_fault_sticky;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit (DEPTH_LOG2 = 4): clear sequencing, directed load/store
// cases, faults, aliasing and randomized accesses against a byte-array reference model.
module tb_data_mem_unit;

  localparam int unsigned DL    = 4;
  localparam int unsigned DEPTH = 2 ** DL;
  localparam int unsigned NB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        fault;
  logic        fault_sticky;

  always #5 clk = ~clk;

  data_mem_unit #(
    .DEPTH_LOG2(DL)
  ) u_dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_mem_read    (mem_read),
    .i_mem_write   (mem_write),
    .i_size        (size),
    .i_unsigned    (uns),
    .i_addr        (addr),
    .i_wd          (wd),
    .o_rd          (rd),
    .o_ready       (ready),
    .o_fault       (fault),
    .o_fault_sticky(fault_sticky)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: plain byte array plus a sticky fault flag.
  logic [7:0] m_mem [NB];
  logic       m_sticky;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic m_misalign(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u,
                                         input logic [31:0] a);
    int unsigned base;
    logic [31:0] v;
    base = a % NB;
    v = 32'h0;
    case (sz)
      2'd0: begin
        v = {24'h0, m_mem[base]};
        if (!u && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = {16'h0, m_mem[base+1], m_mem[base]};
        if (!u && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
    endcase
    return v;
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int unsigned base;
    int unsigned n;
    base = a % NB;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < int'(n); i++) begin
      m_mem[base + i] = d[8*i +: 8];
    end
  endtask

  task automatic idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    size      = 2'd0;
    uns       = 1'b0;
    addr      = 32'h0;
    wd        = 32'h0;
  endtask

  // One request cycle: check combinational outputs against the model, clock it, update the model.
  task automatic access(input logic r, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd_obs, output logic flt_obs);
    logic        flt;
    logic [31:0] exp_rd;
    mem_read  = r;
    mem_write = w;
    size      = sz;
    uns       = u;
    addr      = a;
    wd        = d;
    #1;
    flt    = (r | w) & m_misalign(sz, a);
    exp_rd = (r && !flt) ? m_load(sz, u, a) : 32'h0;
    check_eq("fault", {31'h0, fault}, {31'h0, flt});
    check_eq("rd", rd, exp_rd);
    rd_obs  = rd;
    flt_obs = fault;
    tick();
    if (w && !flt) m_store(sz, a, d);
    if (flt) m_sticky = 1'b1;
    idle();
    check_eq("sticky", {31'h0, fault_sticky}, {31'h0, m_sticky});
  endtask

  // Release reset and expect Ready exactly DEPTH edges later.
  task automatic wait_clear(input string tag);
    for (int i = 1; i <= int'(DEPTH); i++) begin
      tick();
      check_eq(tag, {31'h0, ready}, {31'h0, (i == int'(DEPTH))});
    end
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    check_eq("rst_ready", {31'h0, ready}, 32'h0);
    check_eq("rst_sticky", {31'h0, fault_sticky}, 32'h0);
    check_eq("rst_rd", rd, 32'h0);
    check_eq("rst_fault", {31'h0, fault}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < int'(NB); i++) m_mem[i] = 8'h00;
    m_sticky = 1'b0;
  endtask

  logic [31:0] r_obs;
  logic        f_obs;

  initial begin
    idle();
    reset = 1'b1;
    tick();

    // Plain clear sequence, then every word reads zero.
    apply_reset();
    wait_clear("clear_ready");
    for (int i = 0; i < int'(NB); i += 4) begin
      access(1'b1, 1'b0, 2'd2, 1'b0, 32'(i), 32'h0, r_obs, f_obs);
      check_eq("lw_zero", r_obs, 32'h0);
    end

    // Reset mid-clear; requests during CLEAR are ignored.
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      mem_read  = 1'b1;
      mem_write = 1'b1;
      size      = 2'd3;
      addr      = 32'h1;
      wd        = 32'hFFFF_FFFF;
      #1;
      check_eq("clr_fault", {31'h0, fault}, 32'h0);
      check_eq("clr_rd", rd, 32'h0);
      tick();
      check_eq("clr_ready", {31'h0, ready}, 32'h0);
    end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_clear("reclear_ready");
    check_eq("no_early_sticky", {31'h0, fault_sticky}, 32'h0);

    // Word then byte store.
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, r_obs, f_obs);
    access(1'b0, 1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFF_FFAB, r_obs, f_obs);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r_obs, f_obs);
    check_eq("lw_0x10", r_obs, 32'h11AB_3344);
    access(1'b1, 1'b0, 2'd0, 1'b0, 32'h12, 32'h0, r_obs, f_obs);
    check_eq("lb_0x12", r_obs, 32'hFFFF_FFAB);
    access(1'b1, 1'b0, 2'd0, 1'b1, 32'h12, 32'h0, r_obs, f_obs);
    check_eq("lbu_0x12", r_obs, 32'h0000_00AB);

    // Halfword.
    access(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_8001, r_obs, f_obs);
    access(1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, r_obs, f_obs);
    check_eq("lh_0x22", r_obs, 32'hFFFF_8001);
    access(1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, r_obs, f_obs);
    check_eq("lhu_0x22", r_obs, 32'h0000_8001);
    access(1'b1, 1'b0, 2'd1, 1'b0, 32'h20, 32'h0, r_obs, f_obs);
    check_eq("lh_0x20", r_obs, 32'h0);

    // Aliasing and same-cycle load/store.
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h44, 32'h5A5A_5A5A, r_obs, f_obs);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, r_obs, f_obs);
    check_eq("alias_lw", r_obs, 32'h5A5A_5A5A);
    access(1'b1, 1'b1, 2'd2, 1'b0, 32'h04, 32'h1, r_obs, f_obs);
    check_eq("rw_old", r_obs, 32'h5A5A_5A5A);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, r_obs, f_obs);
    check_eq("rw_new", r_obs, 32'h1);

    // Misaligned store writes nothing and sets the sticky flag.
    check_eq("sticky_before", {31'h0, fault_sticky}, 32'h0);
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h31, 32'hDEAD_BEEF, r_obs, f_obs);
    check_eq("mis_fault", {31'h0, f_obs}, 32'h1);
    check_eq("mis_sticky", {31'h0, fault_sticky}, 32'h1);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, r_obs, f_obs);
    check_eq("mis_unchanged", r_obs, 32'h0);

    // Randomized accesses, aligned half the time, upper address bits random.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      access(1'($urandom), 1'($urandom), sz, 1'($urandom), a, $urandom, r_obs, f_obs);
    end

    // Reset from READY re-clears the array and the sticky flag.
    apply_reset();
    wait_clear("ready_reclear");
    check_eq("sticky_cleared", {31'h0, fault_sticky}, 32'h0);
    for (int i = 0; i < int'(NB); i += 4) begin
      access(1'b1, 1'b0, 2'd2, 1'b0, 32'(i), 32'h0, r_obs, f_obs);
      check_eq("lw_zero2", r_obs, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Byte-addressable data memory with load/store alignment logic. It sits in the memory stage of the single-cycle datapath. It takes the ALU result as the address and the register-file second read port as store data. Its load result drives the memory-data input of the writeback select mux. After reset, a clear sequencer zeroes the array, and the block holds Ready low until the array is initialised.

## Interface
Parameters:
- DEPTH_LOG2, 8, log2 of the number of 32-bit words (DEPTH = 2^DEPTH_LOG2).

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  load request this cycle.
- MemWrite  in  1  store request this cycle.
- Size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- Unsigned  in  1  loads only: 1 zero-extends, 0 sign-extends.
- Addr  in  32  byte address.
- WD  in  32  store data, right-aligned.
- RD  out  32  load data, combinational.
- Ready  out  1  high once the array is cleared and accepting accesses.
- Fault  out  1  combinational: the current request is misaligned or reserved.
- FaultSticky  out  1  registered: a fault has occurred since reset.

## Operation
- Storage is DEPTH × 32-bit words. The word index is Addr[DEPTH_LOG2+1:2].
- Upper address bits are ignored, so addresses alias modulo 4·DEPTH bytes.
- Byte order is little-endian: byte lane k = Addr[1:0] occupies bits [8k+7:8k].
- FSM has two states, CLEAR and READY.
  - Reset forces state to CLEAR and the clear counter to 0.
  - In CLEAR with reset low, each edge writes mem[cnt] = 0 and increments cnt.
  - When cnt = DEPTH-1 is written, state moves to READY.
  - READY is held until the next reset.
- Ready = (state == READY).
- While in CLEAR:
  - RD = 0 and Fault = 0.
  - MemRead and MemWrite are ignored, and no user write occurs.
- Fault = Ready & (MemRead | MemWrite) & misaligned, where misaligned is any of:
  - Size = 11;
  - Size = 01 with Addr[0] = 1;
  - Size = 10 with Addr[1:0] ≠ 00.
- Stores, when Ready & MemWrite & ~Fault:
  - byte: WD[7:0] goes to lane Addr[1:0];
  - half: WD[15:0] goes to lanes {2h+1, 2h}, where h = Addr[1];
  - word: WD goes to the whole word.
  - Unwritten lanes are preserved.
- A faulting store writes nothing.
- Loads, when Ready & MemRead & ~Fault:
  - the addressed byte or half is right-aligned and extended per Unsigned;
  - a word load returns the word unchanged.
- RD = 0 when MemRead = 0, when Fault = 1, or when in CLEAR.
- FaultSticky is set on any edge where Fault = 1. Only reset clears it.
- MemRead and MemWrite both high: the store and the load proceed independently. The load sees pre-store data.

## Timing
- Reset values: state CLEAR, cnt 0, Ready 0, FaultSticky 0, RD 0, Fault 0.
- Ready rises exactly DEPTH rising edges after the first edge sampled with reset low.
- Reset asserted mid-CLEAR restarts the clear at index 0.
- Reset asserted in READY returns the block to CLEAR and re-clears the whole array.
- Load latency: 0 cycles, since RD is combinational from Addr, Size, Unsigned, MemRead and the array.
- Store commit: on the rising edge where the request is valid. The stored data is visible to a load in the following cycle.
- Same-cycle load and store to the same word: the load returns the old contents.
- Fault is combinational in the request cycle. FaultSticky reflects it from the next cycle onward.

## Test plan
- Clear sequence, DEPTH_LOG2 = 4:
  - release reset → Ready stays 0 for 15 edges and is 1 after the 16th;
  - a word load from every address then returns 0x00000000.
- Reset mid-clear: assert reset at clear cycle 7, release it → Ready rises 16 edges after release, not earlier.
- Store word then byte lanes, starting from mem[0x10] = 0:
  - SW 0x11223344 @0x10, then SB 0xAB @0x12 → LW @0x10 = 0x11AB3344;
  - LB @0x12 = 0xFFFFFFAB;
  - LBU @0x12 = 0x000000AB.
- Halfword, after SH 0x8001 @0x22:
  - LH @0x22 = 0xFFFF8001;
  - LHU @0x22 = 0x00008001;
  - LH @0x20 = 0x00000000.
- Misaligned store: SW with Addr 0x31 and WD 0xDEADBEEF →
  - Fault = 1 in that cycle;
  - mem[0x30] is unchanged;
  - FaultSticky = 1 from the next cycle until reset.
- Aliasing and simultaneous access, DEPTH_LOG2 = 4:
  - SW 0x5A5A5A5A @0x44 → LW @0x04 returns 0x5A5A5A5A;
  - same-cycle SW 0x1 and LW @0x04 → RD = 0x5A5A5A5A, and the next-cycle LW returns 0x00000001.
